// File: rtl/dice_turn_scheduler.sv
// Turn/round sequencer for the dice game: round-robin turns, saturating per-player scores,
// winner/tie at game end. Optional macro DICE_SIX_REROLL_EN grants one extra roll after a 6.

module dice_turn_scheduler #(
  parameter int  NUM_PLAYERS = 2,
  parameter int  NUM_ROUNDS  = 3,
  parameter int  SCORE_W     = 6,
  localparam int PW          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int RW          = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           rolled,
  input  logic [2:0]                     roll_value,
  output logic                           turn_active,
  output logic [PW-1:0]                  active_player,
  output logic [RW-1:0]                  round_count,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           score_valid,
  output logic                           invalid_roll,
  output logic                           game_over,
  output logic [PW-1:0]                  winner,
  output logic                           tie
);

  typedef enum logic [1:0] {IDLE, WAIT_ROLL, ADVANCE, DONE} state_t;

  localparam int                 SUM_W     = SCORE_W + 3;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state, next_state;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];

  logic               load_game, score_en, invalid_en;
  logic               step_player, step_round, finish_game;
  logic               roll_legal, last_player, last_round, reroll_pending;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] sat_score;
  logic [PW-1:0]      lead_idx;
  logic               lead_tie;

  assign roll_legal  = (roll_value != 3'd0) && (roll_value != 3'd7);
  assign last_player = (int'(active_player) == NUM_PLAYERS - 1);
  assign last_round  = (int'(round_count) == NUM_ROUNDS - 1);
  assign turn_active = (state == WAIT_ROLL);
  assign game_over   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    next_state  = state;
    load_game   = 1'b0;
    score_en    = 1'b0;
    invalid_en  = 1'b0;
    step_player = 1'b0;
    step_round  = 1'b0;
    finish_game = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load_game  = 1'b1;
          next_state = WAIT_ROLL;
        end
      end
      WAIT_ROLL: begin
        if (rolled) begin
          if (roll_legal) begin
            score_en   = 1'b1;
            next_state = ADVANCE;
          end else begin
            invalid_en = 1'b1;
          end
        end
      end
      ADVANCE: begin
        next_state = WAIT_ROLL;
        if (reroll_pending) begin
          // same player, same round: the bonus roll
        end else if (!last_player) begin
          step_player = 1'b1;
        end else if (!last_round) begin
          step_round = 1'b1;
        end else begin
          finish_game = 1'b1;
          next_state  = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Saturating add for the active player's score.
  always_comb begin
    sum       = SUM_W'(score_q[active_player]) + SUM_W'(roll_value);
    sat_score = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
  end

  // Leader search: strict '>' keeps the lowest index on equal scores.
  always_comb begin
    lead_idx = '0;
    lead_tie = 1'b0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (score_q[p] > score_q[lead_idx]) lead_idx = PW'(p);
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if ((PW'(p) != lead_idx) && (score_q[p] == score_q[lead_idx])) lead_tie = 1'b1;
    end
  end

  // NOTE: the score array is only NUM_PLAYERS entries, so it is reset explicitly like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
      active_player <= '0;
      round_count   <= '0;
      score_valid   <= 1'b0;
      invalid_roll  <= 1'b0;
      winner        <= '0;
      tie           <= 1'b0;
    end else begin
      score_valid  <= score_en;
      invalid_roll <= invalid_en;
      if (load_game) begin
        for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
        active_player <= '0;
        round_count   <= '0;
        winner        <= '0;
        tie           <= 1'b0;
      end
      if (score_en)    score_q[active_player] <= sat_score;
      if (step_player) active_player <= active_player + PW'(1);
      if (step_round) begin
        active_player <= '0;
        round_count   <= round_count + RW'(1);
      end
      if (finish_game) begin
        winner <= lead_idx;
        tie    <= lead_tie;
      end
    end
  end

`ifdef DICE_SIX_REROLL_EN
  // bonus_taken remembers that this turn already used its extra roll; cleared on turn change.
  logic bonus_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reroll_pending <= 1'b0;
      bonus_taken    <= 1'b0;
    end else if (load_game) begin
      reroll_pending <= 1'b0;
      bonus_taken    <= 1'b0;
    end else if (score_en) begin
      reroll_pending <= (roll_value == 3'd6) && !bonus_taken;
    end else if (state == ADVANCE) begin
      bonus_taken    <= reroll_pending;
      reroll_pending <= 1'b0;
    end
  end
`else
  assign reroll_pending = 1'b0;
`endif

  always_comb begin
    scores = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) scores[p*SCORE_W +: SCORE_W] = score_q[p];
  end

endmodule

// File: tb/tb_dice_turn_scheduler.sv
// Scoreboard bench: two scheduler instances (6-bit and 3-bit scores) share one random stimulus
// stream; a turn-count reference model predicts every event and a monitor checks them.

module tb_dice_turn_scheduler;

  localparam int NP   = 2;
  localparam int NR   = 3;
  localparam int PW   = 1;
  localparam int SW_A = 6;
  localparam int SW_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rolled = 1'b0;
  logic [2:0] roll_value = 3'd0;

  logic              turn_active_a, score_valid_a, invalid_roll_a, game_over_a, tie_a;
  logic [PW-1:0]     active_player_a, winner_a;
  logic [3:0]        round_count_a;
  logic [NP*SW_A-1:0] scores_a;
  logic              turn_active_b, score_valid_b, invalid_roll_b, game_over_b, tie_b;
  logic [PW-1:0]     active_player_b, winner_b;
  logic [3:0]        round_count_b;
  logic [NP*SW_B-1:0] scores_b;

  always #5 clk = ~clk;

  dice_turn_scheduler #(.NUM_PLAYERS(NP), .NUM_ROUNDS(NR), .SCORE_W(SW_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .rolled(rolled), .roll_value(roll_value),
    .turn_active(turn_active_a), .active_player(active_player_a), .round_count(round_count_a),
    .scores(scores_a), .score_valid(score_valid_a), .invalid_roll(invalid_roll_a),
    .game_over(game_over_a), .winner(winner_a), .tie(tie_a)
  );

  dice_turn_scheduler #(.NUM_PLAYERS(NP), .NUM_ROUNDS(NR), .SCORE_W(SW_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .rolled(rolled), .roll_value(roll_value),
    .turn_active(turn_active_b), .active_player(active_player_b), .round_count(round_count_b),
    .scores(scores_b), .score_valid(score_valid_b), .invalid_roll(invalid_roll_b),
    .game_over(game_over_b), .winner(winner_b), .tie(tie_b)
  );

  typedef enum int {EV_TURN, EV_SCORE, EV_INVALID, EV_DONE} ev_kind_t;
  typedef enum int {PH_IDLE, PH_WAIT, PH_ADV, PH_DONE} phase_t;

  typedef struct {
    ev_kind_t           kind;
    int                 due;
    int                 player;
    int                 round;
    logic [NP*SW_A-1:0] s_a;
    logic [NP*SW_B-1:0] s_b;
    int                 win_a, tie_a, win_b, tie_b;
  } ev_t;

  ev_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // ---------------- reference model ----------------
  phase_t m_phase = PH_IDLE;
  int     m_turns = 0;
  bit     m_bonus = 1'b0;
  bit     m_reroll = 1'b0;
  int     sc_a[NP];
  int     sc_b[NP];

  function automatic logic [NP*SW_A-1:0] pack_a();
    logic [NP*SW_A-1:0] r = '0;
    for (int p = 0; p < NP; p++) r[p*SW_A +: SW_A] = SW_A'(sc_a[p]);
    return r;
  endfunction

  function automatic logic [NP*SW_B-1:0] pack_b();
    logic [NP*SW_B-1:0] r = '0;
    for (int p = 0; p < NP; p++) r[p*SW_B +: SW_B] = SW_B'(sc_b[p]);
    return r;
  endfunction

  function automatic void best_of(input int sc[NP], output int w, output int t);
    int n = 0;
    w = 0;
    for (int p = 1; p < NP; p++) if (sc[p] > sc[w]) w = p;
    for (int p = 0; p < NP; p++) if (sc[p] == sc[w]) n++;
    t = (n > 1) ? 1 : 0;
  endfunction

  task automatic push_event(input ev_kind_t kind);
    ev_t e;
    e.kind   = kind;
    e.due    = cyc + 1;
    e.player = m_turns % NP;
    e.round  = m_turns / NP;
    e.s_a    = pack_a();
    e.s_b    = pack_b();
    best_of(sc_a, e.win_a, e.tie_a);
    best_of(sc_b, e.win_b, e.tie_b);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_turns  = 0;
    m_bonus  = 1'b0;
    m_reroll = 1'b0;
    for (int p = 0; p < NP; p++) begin
      sc_a[p] = 0;
      sc_b[p] = 0;
    end
  endtask

  // Predicts the effect of the coming clock edge given the inputs just driven.
  task automatic model_apply(input logic st, input logic rl, input logic [2:0] v);
    int p;
    int val;
    case (m_phase)
      PH_IDLE, PH_DONE: begin
        if (st) begin
          model_reset();
          m_phase = PH_WAIT;
          push_event(EV_TURN);
        end
      end
      PH_WAIT: begin
        if (rl) begin
          val = int'(v);
          p   = m_turns % NP;
          if (val >= 1 && val <= 6) begin
            sc_a[p] = (sc_a[p] + val > 63) ? 63 : sc_a[p] + val;
            sc_b[p] = (sc_b[p] + val > 7) ? 7 : sc_b[p] + val;
`ifdef DICE_SIX_REROLL_EN
            m_reroll = (val == 6) && !m_bonus;
`endif
            m_phase = PH_ADV;
            push_event(EV_SCORE);
          end else begin
            push_event(EV_INVALID);
          end
        end
      end
      PH_ADV: begin
        if (m_reroll) begin
          m_reroll = 1'b0;
          m_bonus  = 1'b1;
          m_phase  = PH_WAIT;
          push_event(EV_TURN);
        end else begin
          m_bonus = 1'b0;
          m_turns++;
          if (m_turns == NP * NR) begin
            m_phase = PH_DONE;
            push_event(EV_DONE);
          end else begin
            m_phase = PH_WAIT;
            push_event(EV_TURN);
          end
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- monitor ----------------
  logic prev_turn = 1'b0;
  logic prev_go   = 1'b0;

  task automatic handle(input ev_kind_t kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind=%0d expected none", int'(kind));
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", int'(kind), int'(e.kind));
    if (kind != e.kind) return;
    check("event_latency", cyc, e.due);
    check("scores_a", 32'(scores_a), 32'(e.s_a));
    check("scores_b", 32'(scores_b), 32'(e.s_b));
    case (kind)
      EV_DONE: begin
        check("winner_a", 32'(winner_a), e.win_a);
        check("tie_a", 32'(tie_a), e.tie_a);
        check("winner_b", 32'(winner_b), e.win_b);
        check("tie_b", 32'(tie_b), e.tie_b);
        check("game_over_b", 32'(game_over_b), 1);
      end
      default: begin
        check("active_player_a", 32'(active_player_a), e.player);
        check("active_player_b", 32'(active_player_b), e.player);
        check("round_count_a", 32'(round_count_a), e.round);
        if (kind == EV_SCORE)   check("score_valid_b", 32'(score_valid_b), 1);
        if (kind == EV_INVALID) check("invalid_roll_b", 32'(invalid_roll_b), 1);
        if (kind == EV_TURN) begin
          check("turn_active_b", 32'(turn_active_b), 1);
          check("game_over_a_on_turn", 32'(game_over_a), 0);
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (score_valid_a)                handle(EV_SCORE);
      if (invalid_roll_a)               handle(EV_INVALID);
      if (turn_active_a && !prev_turn)  handle(EV_TURN);
      if (game_over_a && !prev_go)      handle(EV_DONE);
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_event: got none expected kind=%0d", int'(exp_q[0].kind));
        void'(exp_q.pop_front());
      end
    end
    prev_turn <= turn_active_a;
    prev_go   <= game_over_a;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic st, input logic rl, input logic [2:0] v);
    @(negedge clk);
    start      = st;
    rolled     = rl;
    roll_value = v;
    if (!rst) model_apply(st, rl, v);
  endtask

  task automatic wait_phase(input phase_t ph);
    int n = 0;
    while (m_phase != ph && n < 60) begin
      step(1'b0, 1'b0, 3'd0);
      n++;
    end
    if (m_phase != ph) bound_fail("wait_phase");
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step(1'b0, 1'b0, 3'd0);
      n++;
    end
    if (exp_q.size() != 0) bound_fail("drain");
  endtask

  task automatic start_game();
    step(1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
  endtask

  // One roll in WAIT_ROLL; after a legal roll a junk pulse may hit the ADVANCE cycle.
  task automatic roll(input logic [2:0] v);
    wait_phase(PH_WAIT);
    step(1'b0, 1'b1, v);
    if (m_phase == PH_ADV) step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    else                   step(1'b0, 1'b0, 3'd0);
  endtask

  // Finishes the current game; v=0 means random legal values.
  task automatic play_out(input int v);
    int n = 0;
    while (m_phase != PH_DONE && n < 100) begin
      roll((v == 0) ? 3'($urandom_range(1, 6)) : 3'(v));
      n++;
    end
    if (m_phase != PH_DONE) bound_fail("play_out");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_turn_active"}, 32'(turn_active_a), 0);
    check({tag, "_active_player"}, 32'(active_player_a), 0);
    check({tag, "_round_count"}, 32'(round_count_a), 0);
    check({tag, "_scores_a"}, 32'(scores_a), 0);
    check({tag, "_scores_b"}, 32'(scores_b), 0);
    check({tag, "_score_valid"}, 32'(score_valid_a), 0);
    check({tag, "_invalid_roll"}, 32'(invalid_roll_a), 0);
    check({tag, "_game_over"}, 32'(game_over_a), 0);
    check({tag, "_winner"}, 32'(winner_a), 0);
    check({tag, "_tie"}, 32'(tie_a), 0);
  endtask

  task automatic random_game();
    int n = 0;
    int r;
    step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    while (m_phase != PH_DONE && n < 400) begin
      r = $urandom_range(0, 9);
      if (m_phase == PH_WAIT) begin
        if (r < 6)       step(1'b0, 1'b1, 3'($urandom_range(1, 6)));
        else if (r == 6) step(1'b0, 1'b1, ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd0);
        else if (r == 7) step(1'b1, 1'b0, 3'd0);
        else             step(1'b0, 1'b0, 3'd0);
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      n++;
    end
    if (m_phase != PH_DONE) bound_fail("random_game_end");
    repeat (3) step(1'b0, 1'b1, 3'($urandom_range(0, 7)));
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset_init");
    rst = 1'b0;
    step(1'b0, 1'b1, 3'd5);  // rolled in IDLE is ignored
    step(1'b0, 1'b0, 3'd0);

    // Default game: 3,5,2,1,6,4
    start_game();
    roll(3'd3); roll(3'd5); roll(3'd2); roll(3'd1); roll(3'd6); roll(3'd4);
    play_out(0);
    drain();
`ifndef DICE_SIX_REROLL_EN
    check("t2_scores_a", 32'(scores_a), 32'd651);
    check("t2_winner_a", 32'(winner_a), 0);
    check("t2_tie_a", 32'(tie_a), 0);
    check("t2_scores_b", 32'(scores_b), 32'd63);
    check("t2_tie_b", 32'(tie_b), 1);
`endif

    // Tie game: all 4s
    start_game();
    play_out(4);
    drain();
    check("t3_scores_a", 32'(scores_a), 32'd780);
    check("t3_winner_a", 32'(winner_a), 0);
    check("t3_tie_a", 32'(tie_a), 1);
    check("t3_scores_b", 32'(scores_b), 32'd63);

    // Invalid rolls, then reset mid-game in round 1
    start_game();
    roll(3'd7); roll(3'd0); roll(3'd2); roll(3'd5);
    wait_phase(PH_WAIT);
    drain();
    check("t4_scores_a", 32'(scores_a), 32'd322);
    check("t4_active_player", 32'(active_player_a), 0);
    check("t1_round_before_rst", 32'(round_count_a), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 3'd0);
    check_zero("after_reset");

    // Saturation with all 6s, then restart from DONE
    start_game();
    play_out(6);
    drain();
`ifdef DICE_SIX_REROLL_EN
    check("t5_scores_a", 32'(scores_a), 32'd2340);
`else
    check("t5_scores_a", 32'(scores_a), 32'd1170);
`endif
    check("t5_scores_b", 32'(scores_b), 32'd63);
    check("t5_tie_b", 32'(tie_b), 1);
    start_game();
    drain();
    check("restart_scores", 32'(scores_a), 0);
    check("restart_player", 32'(active_player_a), 0);
    check("restart_turn_active", 32'(turn_active_a), 1);
    check("restart_game_over", 32'(game_over_a), 0);

    // Six-reroll behaviour: 6, 6, 1
    roll(3'd6); roll(3'd6); roll(3'd1);
    wait_phase(PH_WAIT);
    drain();
`ifdef DICE_SIX_REROLL_EN
    check("t6_scores_a", 32'(scores_a), 32'd76);
    check("t6_scores_b", 32'(scores_b), 32'd15);
    check("t6_active_player", 32'(active_player_a), 0);
`else
    check("t6_scores_a", 32'(scores_a), 32'd391);
    check("t6_scores_b", 32'(scores_b), 32'd55);
    check("t6_active_player", 32'(active_player_a), 1);
`endif
    play_out(0);
    drain();

    for (int g = 0; g < 6; g++) random_game();

    repeat (4) step(1'b0, 1'b0, 3'd0);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
